// File: rtl/sonic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sonic_scan_ctrl
// Purpose : Round-robin scheduler for HC-SR04-style ultrasonic rangers that
//           share one echo-width counter. Each enabled channel gets one fixed
//           time slot: trigger pulse, echo measurement, result write-back.
//           Results are read through a registered port with unread flags.
// Rev     : 1.0  initial release
// ============================================================================
module sonic_scan_ctrl #(
    parameter int               N_SENSORS   = 4,
    parameter int               CNT_W       = 24,
    parameter int               TRIG_CYCLES = 500,
    parameter int               SLOT_CYCLES = 2500000,
    parameter int               MAX_WIDTH   = 1800000,
    parameter logic [CNT_W-1:0] OOR_CODE    = 24'h000FFF,
    // Derived channel-index width; not meant to be overridden.
    parameter int               CH_W        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic [N_SENSORS-1:0] ch_mask,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic                 busy,
    output logic [CH_W-1:0]      cur_ch,
    output logic                 done,
    output logic [CH_W-1:0]      done_ch,
    input  logic                 rd_en,
    input  logic [CH_W-1:0]      rd_addr,
    output logic [CNT_W-1:0]     rd_data,
    output logic [N_SENSORS-1:0] new_flags
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_WAIT  = 3'd2,
        S_MEAS  = 3'd3,
        S_GUARD = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX_WIDTH = CNT_W'(MAX_WIDTH);

    state_t                 r_state;
    state_t                 w_next;
    logic [N_SENSORS-1:0]   r_echo_s1;
    logic [N_SENSORS-1:0]   r_echo_s2;
    logic [CNT_W-1:0]       r_slot_cnt;
    logic [CNT_W-1:0]       r_width;
    logic [CH_W-1:0]        r_cur_ch;
    logic [N_SENSORS-1:0]   r_trig;
    logic [N_SENSORS-1:0]   r_new;
    logic                   r_done;
    logic [CH_W-1:0]        r_done_ch;
    logic [CNT_W-1:0]       r_rd_data;
    logic [CNT_W-1:0]       r_results [N_SENSORS];

    logic                   w_echo;
    logic                   w_slot_end;
    logic                   w_start;
    logic                   w_write;
    logic                   w_rd_valid;
    logic                   w_sel_found;
    logic [CH_W-1:0]        w_sel;
    logic [CH_W-1:0]        w_cand;
    logic [CNT_W-1:0]       w_wr_val;
    logic [CNT_W-1:0]       w_width_inc;

    assign w_echo      = r_echo_s2[r_cur_ch];
    assign w_slot_end  = (r_slot_cnt == C_SLOT_LAST);
    assign w_width_inc = (r_width == {CNT_W{1'b1}}) ? r_width : r_width + CNT_W'(1);
    assign w_rd_valid  = (int'(rd_addr) < N_SENSORS);

    // Two-flop synchroniser on every raw echo input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
        end
    end

    // Pick the lowest enabled channel strictly after the last one, wrapping.
    always_comb begin
        w_sel       = r_cur_ch;
        w_sel_found = 1'b0;
        w_cand      = '0;
        for (int i = 1; i <= N_SENSORS; i++) begin
            w_cand = CH_W'((int'(r_cur_ch) + i) % N_SENSORS);
            if (!w_sel_found && ch_mask[w_cand]) begin
                w_sel       = w_cand;
                w_sel_found = 1'b1;
            end
        end
    end

    // Next-state and write decision. A timeout on the last slot cycle returns
    // straight to IDLE so every slot is exactly SLOT_CYCLES long.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_write  = 1'b0;
        w_wr_val = r_width;
        case (r_state)
            S_IDLE: begin
                if (run && w_sel_found) begin
                    w_next  = S_TRIG;
                    w_start = 1'b1;
                end
            end
            S_TRIG: begin
                if (r_slot_cnt == C_TRIG_LAST) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_slot_end) begin
                    w_write  = 1'b1;
                    w_wr_val = OOR_CODE;
                    w_next   = S_IDLE;
                end else if (w_echo) begin
                    w_next = S_MEAS;
                end
            end
            S_MEAS: begin
                if (!w_echo) begin
                    w_write  = 1'b1;
                    w_wr_val = (r_width > C_MAX_WIDTH) ? OOR_CODE : r_width;
                    w_next   = w_slot_end ? S_IDLE : S_GUARD;
                end else if (w_slot_end) begin
                    w_write  = 1'b1;
                    w_wr_val = OOR_CODE;
                    w_next   = S_IDLE;
                end
            end
            S_GUARD: begin
                if (w_slot_end) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Slot counter, width counter, channel select and trigger output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt <= '0;
            r_width    <= '0;
            r_cur_ch   <= CH_W'(N_SENSORS - 1);
            r_trig     <= '0;
        end else begin
            if (w_start) begin
                r_cur_ch   <= w_sel;
                r_slot_cnt <= '0;
                r_width    <= '0;
                r_trig     <= N_SENSORS'(1) << w_sel;
            end else if (r_state != S_IDLE) begin
                r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            end
            if (r_state == S_TRIG && r_slot_cnt == C_TRIG_LAST) begin
                r_trig <= '0;
            end
            // The cycle that first sees echo high counts as width 1.
            if (r_state == S_WAIT && w_echo) begin
                r_width <= CNT_W'(1);
            end else if (r_state == S_MEAS && w_echo) begin
                r_width <= w_width_inc;
            end
        end
    end

    // Result store, done pulse, read port and unread flags (write beats read).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SENSORS; i++) begin
                r_results[i] <= '0;
            end
            r_new     <= '0;
            r_done    <= 1'b0;
            r_done_ch <= '0;
            r_rd_data <= '0;
        end else begin
            r_done <= w_write;
            if (rd_en) begin
                if (w_rd_valid) begin
                    r_rd_data      <= r_results[rd_addr];
                    r_new[rd_addr] <= 1'b0;
                end else begin
                    r_rd_data <= '0;
                end
            end
            if (w_write) begin
                r_results[r_cur_ch] <= w_wr_val;
                r_new[r_cur_ch]     <= 1'b1;
                r_done_ch           <= r_cur_ch;
            end
        end
    end

    assign trig      = r_trig;
    assign busy      = (r_state != S_IDLE);
    assign cur_ch    = r_cur_ch;
    assign done      = r_done;
    assign done_ch   = r_done_ch;
    assign rd_data   = r_rd_data;
    assign new_flags = r_new;

endmodule
`default_nettype wire

// File: tb/tb_sonic_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sonic_scan_ctrl
// Purpose : Self-checking bench for sonic_scan_ctrl. A slot-level model
//           predicts channel order, echo results, done timing, read data and
//           unread flags from the pulse geometry of each slot.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sonic_scan_ctrl;

    localparam int          N   = 4;
    localparam int          TC  = 5;
    localparam int          SC  = 200;
    localparam int          MX  = 150;
    localparam logic [23:0] OOR = 24'h000FFF;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        run     = 1'b0;
    logic [3:0]  ch_mask = 4'b0;
    logic [3:0]  echo    = 4'b0;
    logic        rd_en   = 1'b0;
    logic [1:0]  rd_addr = 2'b0;
    logic [3:0]  trig;
    logic        busy;
    logic [1:0]  cur_ch;
    logic        done;
    logic [1:0]  done_ch;
    logic [23:0] rd_data;
    logic [3:0]  new_flags;

    sonic_scan_ctrl #(
        .N_SENSORS   (4),
        .CNT_W       (24),
        .TRIG_CYCLES (TC),
        .SLOT_CYCLES (SC),
        .MAX_WIDTH   (MX),
        .OOR_CODE    (OOR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .ch_mask   (ch_mask),
        .echo      (echo),
        .trig      (trig),
        .busy      (busy),
        .cur_ch    (cur_ch),
        .done      (done),
        .done_ch   (done_ch),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .new_flags (new_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [23:0] m_res [N];
    logic [3:0]  m_flag;
    logic [3:0]  m_mask;
    int          m_last;
    int          prev_rise;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_ch(input logic [3:0] mask, input int last);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_res[i] = '0;
        m_flag    = '0;
        m_last    = N - 1;
        prev_rise = -1;
    endtask

    // One scheduled slot. Echo on the served channel is raised at slot cycle k
    // for w cycles (after the synchroniser it is seen on cycles [k+2, k+w+2)).
    // Slot cycle 0 is the first negedge where trig is high.
    task automatic do_slot(input bit has_echo, input int k, input int w,
                           input int rd_at, input int rd_ch,
                           input logic nrun, input logic [3:0] nmask, input bit noise);
        int          exp_ch, d, t, trig_cnt, done_cnt, done_at, other_trig;
        logic [23:0] e;
        logic [1:0]  dch;
        bit          rd_pend;
        exp_ch = next_ch(m_mask, m_last);
        t = 0;
        while (trig === 4'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("trig_select", {28'b0, trig}, 32'(1) << exp_ch);
        chk("cur_ch", {30'b0, cur_ch}, exp_ch);
        if (prev_rise >= 0) chk("slot_period", cyc - prev_rise, SC + 1);
        prev_rise = cyc;
        if (!has_echo || (k + w + 2) > (SC - 1)) begin
            e = OOR;
            d = SC;
        end else begin
            e = (w > MX) ? OOR : 24'(w);
            d = k + w + 3;
        end
        trig_cnt = 0; done_cnt = 0; done_at = -1; other_trig = 0; dch = '0; rd_pend = 1'b0;
        for (int c = 0; c <= SC; c++) begin
            if (rd_pend) begin
                chk("rd_data", {8'b0, rd_data}, {8'b0, m_res[rd_ch]});
                m_flag[rd_ch] = 1'b0;
                rd_en   = 1'b0;
                rd_pend = 1'b0;
            end
            if (c == d) begin
                m_res[exp_ch]  = e;
                m_flag[exp_ch] = 1'b1;
            end
            if (trig[exp_ch]) trig_cnt++;
            if ((trig & ~(4'b0001 << exp_ch)) != 4'b0) other_trig++;
            if (done) begin
                done_cnt++;
                done_at = c;
                dch     = done_ch;
            end
            if (c == SC) chk("busy_at_idle", {31'b0, busy}, 0);
            echo = noise ? 4'($urandom) : 4'b0;
            echo[exp_ch] = has_echo && (c >= k) && (c < k + w);
            if (c == rd_at) begin
                rd_en   = 1'b1;
                rd_addr = 2'(rd_ch);
                rd_pend = 1'b1;
            end
            if (c == SC / 2) begin
                run     = nrun;
                ch_mask = nmask;
            end
            @(negedge clk);
        end
        echo = 4'b0;
        chk("trig_width", trig_cnt, TC);
        chk("trig_other", other_trig, 0);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, d);
        chk("done_ch", {30'b0, dch}, exp_ch);
        chk("new_flags", {28'b0, new_flags}, {28'b0, m_flag});
        m_last = exp_ch;
        m_mask = nmask;
        if (!nrun || nmask == 4'b0) prev_rise = -1;
    endtask

    task automatic idle_check(input string tag, input int n);
        int viol = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (trig != 4'b0 || busy || done) viol++;
        end
        chk(tag, viol, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit          r_he;
    int          r_k, r_w, r_at, r_ch;
    logic [3:0]  r_nm;

    initial begin
        model_reset();
        m_mask = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig",    {28'b0, trig}, 0);
        chk("rst_busy",    {31'b0, busy}, 0);
        chk("rst_done",    {31'b0, done}, 0);
        chk("rst_cur_ch",  {30'b0, cur_ch}, 3);
        chk("rst_done_ch", {30'b0, done_ch}, 0);
        chk("rst_rd_data", {8'b0, rd_data}, 0);
        chk("rst_flags",   {28'b0, new_flags}, 0);
        reset_n = 1'b1;
        idle_check("idle_no_run", 5);

        // Basic measurement on ch0, then round robin over mask 1011
        ch_mask = 4'b0001; m_mask = 4'b0001; run = 1'b1;
        do_slot(1, 25, 40, -1, 0, 1'b1, 4'b0001, 1'b0);
        do_slot(1, 30, 10,  2, 0, 1'b1, 4'b1011, 1'b0);
        do_slot(1, 12, 20,  5, 0, 1'b1, 4'b1011, 1'b0);
        do_slot(1, 40, 30, 10, 1, 1'b1, 4'b1011, 1'b0);
        // ch0 echo held past slot end, ch1 no echo with a read colliding
        // with its own write, ch3 echo wider than MAX_WIDTH
        do_slot(1, 100, 150, 20, 3, 1'b1, 4'b1011, 1'b0);
        do_slot(0, 0, 0, SC - 1, 1, 1'b1, 4'b1011, 1'b0);
        do_slot(1, 10, 160, 3, 1, 1'b1, 4'b1011, 1'b0);
        // run drops while ch0 is measuring; slot still completes
        do_slot(1, 80, 50, -1, 0, 1'b0, 4'b1011, 1'b0);
        idle_check("idle_run_off", 30);
        run = 1'b1; ch_mask = 4'b0000; m_mask = 4'b0000;
        idle_check("idle_mask_zero", 20);
        ch_mask = 4'b1011; m_mask = 4'b1011;

        // Randomized slots with noise on unselected channels
        for (int s = 0; s < 12; s++) begin
            r_he = ($urandom_range(0, 4) != 0);
            r_k  = $urandom_range(3, 150);
            r_w  = $urandom_range(1, 190);
            r_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, SC - 1) : -1;
            r_ch = $urandom_range(0, 3);
            r_nm = 4'($urandom_range(1, 15));
            do_slot(r_he, r_k, r_w, r_at, r_ch, 1'b1, r_nm, 1'b1);
        end
        do_slot(1, 20, 25, 7, 2, 1'b1, 4'b0001, 1'b0);

        // Asynchronous reset while trig[0] is high
        chk("pre_reset_trig0", {31'b0, trig[0]}, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_trig",    {28'b0, trig}, 0);
        chk("arst_busy",    {31'b0, busy}, 0);
        chk("arst_flags",   {28'b0, new_flags}, 0);
        chk("arst_rd_data", {8'b0, rd_data}, 0);
        chk("arst_cur_ch",  {30'b0, cur_ch}, 3);
        @(negedge clk);
        model_reset();
        ch_mask = 4'b1111; m_mask = 4'b1111; run = 1'b1;
        reset_n = 1'b1;
        do_slot(1, 20, 33, 2, 0, 1'b0, 4'b1111, 1'b0);
        idle_check("idle_end", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
